// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing fetch/execute/write-back for the 8-bit multicycle datapath
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the core and raise illegalOp.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic       pcSelect,
  output logic       pcEnable,
  output logic       adrSelect,
  output logic       ir1En,
  output logic       ir2En,
  output logic       regSelect,
  output logic       wd3Select,
  output logic       regWrite,
  output logic       op1Sel,
  output logic       op2Sel,
  output logic       aluOutEn,
  output logic [2:0] aluControl,
  output logic       memWrite,
  output logic       halted,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_ALU, S_ALUWB, S_INC, S_LD, S_ST, S_JMP, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_op_q, alu_op_d;

  // ALU operation is captured at dispatch so ALU/ALUWB outputs depend only on registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH1;
      alu_op_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegalOp = illegal_q & ~reset;
`else
  assign illegalOp = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        alu_op_d = opcode[2:0] - 3'd1;
        case (opcode)
          4'h0:                         state_d = S_FETCH1;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: state_d = S_ALU;
          4'h6:                         state_d = S_INC;
          4'h8:                         state_d = S_LD;
          4'h9:                         state_d = S_ST;
          4'hA:                         state_d = S_JMP;
          4'hF:                         state_d = S_HALT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH1;
`endif
          end
        endcase
      end
      S_ALU:   state_d = S_ALUWB;
      S_ALUWB, S_INC, S_LD, S_ST, S_JMP: state_d = S_FETCH1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH1;
    endcase
  end

  always_comb begin
    pcSelect   = 1'b0;
    pcEnable   = 1'b0;
    adrSelect  = 1'b0;
    ir1En      = 1'b0;
    ir2En      = 1'b0;
    regSelect  = 1'b0;
    wd3Select  = 1'b0;
    regWrite   = 1'b0;
    op1Sel     = 1'b0;
    op2Sel     = 1'b0;
    aluOutEn   = 1'b0;
    aluControl = 3'b000;
    memWrite   = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH1: begin
        ir1En    = 1'b1;
        op2Sel   = 1'b1;
        pcEnable = 1'b1;
      end
      S_FETCH2: begin
        ir2En    = 1'b1;
        op2Sel   = 1'b1;
        pcEnable = 1'b1;
      end
      S_ALU: begin
        regSelect  = 1'b1;
        op1Sel     = 1'b1;
        aluControl = alu_op_q;
        aluOutEn   = 1'b1;
      end
      S_ALUWB: begin
        regSelect  = 1'b1;
        op1Sel     = 1'b1;
        aluControl = alu_op_q;
        wd3Select  = 1'b1;
        regWrite   = 1'b1;
      end
      S_INC: begin
        op1Sel    = 1'b1;
        op2Sel    = 1'b1;
        aluOutEn  = 1'b1;
        wd3Select = 1'b1;
        regWrite  = 1'b1;
      end
      S_LD: begin
        adrSelect = 1'b1;
        regWrite  = 1'b1;
      end
      S_ST: begin
        adrSelect = 1'b1;
        memWrite  = 1'b1;
      end
      S_JMP: begin
        pcSelect = 1'b1;
        pcEnable = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset suppresses every side effect regardless of where the FSM was.
    if (reset) begin
      pcEnable = 1'b0;
      ir1En    = 1'b0;
      ir2En    = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
      aluOutEn = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule
